// File: rtl/s100_bus_exerciser.sv
// S-100 bus exerciser: generates address/data patterns and emulated bus
// strobes for a four-state read/write cycle, paced by a prescaler or by single-steps.
module s100_bus_exerciser #(
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PRESCALE_W = 24,
    parameter int unsigned HB_LOG2    = 8
) (
    input  logic                  pll0_2MHz,
    input  logic                  s100_n_RESET,
    input  logic                  pll0_LOCKED,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [1:0]            mode,
    input  logic                  run,
    input  logic                  step,
    output logic [ADDR_W-1:0]     S100adr,
    output logic [DATA_W-1:0]     s100_DO,
    output logic [7:0]            sbcLEDS,
    output logic                  s100_pSYNC,
    output logic                  s100_pSTVAL,
    output logic                  s100_pDBIN,
    output logic                  s100_n_pWR,
    output logic                  s100_sMWRT,
    output logic                  busy,
    output logic                  overrun,
    output logic                  seg7_dp
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_STATUS = 2'd2,
        ST_DATA   = 2'd3
    } state_t;

    state_t                  state;
    logic [PRESCALE_W-1:0]   pcnt;
    logic                    step_q;
    logic                    pending;
    logic                    cyc_wr;
    logic                    wr_next;
    logic [ADDR_W-1:0]       bin;
    logic [ADDR_W-1:0]       walk;
    logic [HB_LOG2-1:0]      hb_cnt;

    logic                    tick_c;
    logic                    start_c;
    logic [ADDR_W-1:0]       bin_nxt;
    logic [ADDR_W-1:0]       walk_nxt;
    logic [ADDR_W-1:0]       adr_nxt;

    // Tick source: prescaler terminal count while running, step rising edge while stopped
    always_comb begin
        tick_c = 1'b0;
        if (pll0_LOCKED) begin
            if (run) begin
                tick_c = (pcnt >= prescale);
            end else begin
                tick_c = step & ~step_q;
            end
        end
    end

    // A cycle starts from IDLE on a tick or leftover pending, or straight out of DATA when pending
    always_comb begin
        start_c = ((state == ST_IDLE) && (tick_c || pending)) ||
                  ((state == ST_DATA) && pending);
    end

    // Pattern generator: next counter, walking register and address for the selected mode
    always_comb begin
        bin_nxt  = bin;
        walk_nxt = walk;
        adr_nxt  = bin;
        case (mode)
            2'b00: begin
                bin_nxt = bin + ADDR_W'(1);
                adr_nxt = bin_nxt;
            end
            2'b01: begin
                bin_nxt = bin - ADDR_W'(1);
                adr_nxt = bin_nxt;
            end
            2'b10: begin
                walk_nxt = {walk[ADDR_W-2:0], walk[ADDR_W-1]};
                adr_nxt  = walk_nxt;
            end
            default: begin
                bin_nxt = bin + ADDR_W'(1);
                adr_nxt = bin_nxt ^ (bin_nxt >> 1);
            end
        endcase
    end

    // Prescaler: counts only while free-running with a locked PLL, otherwise parked at zero
    always_ff @(posedge pll0_2MHz or negedge s100_n_RESET) begin
        if (!s100_n_RESET) begin
            pcnt <= '0;
        end else if (run && pll0_LOCKED) begin
            pcnt <= (pcnt >= prescale) ? '0 : pcnt + PRESCALE_W'(1);
        end else begin
            pcnt <= '0;
        end
    end

    // Step edge history
    always_ff @(posedge pll0_2MHz or negedge s100_n_RESET) begin
        if (!s100_n_RESET) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // Bus FSM with registered strobes, pending/overrun tracking, pattern load and heartbeat
    always_ff @(posedge pll0_2MHz or negedge s100_n_RESET) begin
        if (!s100_n_RESET) begin
            state       <= ST_IDLE;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            cyc_wr      <= 1'b0;
            wr_next     <= 1'b0;
            bin         <= '0;
            walk        <= ADDR_W'(1);
            S100adr     <= '0;
            s100_DO     <= '0;
            sbcLEDS     <= 8'hFF;
            s100_pSYNC  <= 1'b0;
            s100_pSTVAL <= 1'b1;
            s100_pDBIN  <= 1'b0;
            s100_n_pWR  <= 1'b1;
            s100_sMWRT  <= 1'b0;
            busy        <= 1'b0;
            hb_cnt      <= '0;
            seg7_dp     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick_c || pending) begin
                        state      <= ST_SYNC;
                        pending    <= pending & tick_c;
                        s100_pSYNC <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_SYNC: begin
                    state       <= ST_STATUS;
                    s100_pSYNC  <= 1'b0;
                    s100_pSTVAL <= 1'b0;
                    s100_sMWRT  <= cyc_wr;
                    if (tick_c) begin
                        if (pending) overrun <= 1'b1;
                        else         pending <= 1'b1;
                    end
                end
                ST_STATUS: begin
                    state       <= ST_DATA;
                    s100_pSTVAL <= 1'b1;
                    s100_pDBIN  <= ~cyc_wr;
                    s100_n_pWR  <= ~cyc_wr;
                    if (tick_c) begin
                        if (pending) overrun <= 1'b1;
                        else         pending <= 1'b1;
                    end
                end
                default: begin
                    s100_pDBIN <= 1'b0;
                    s100_n_pWR <= 1'b1;
                    s100_sMWRT <= 1'b0;
                    hb_cnt     <= hb_cnt + HB_LOG2'(1);
                    if (&hb_cnt) seg7_dp <= ~seg7_dp;
                    if (pending) begin
                        state      <= ST_SYNC;
                        pending    <= 1'b0;
                        s100_pSYNC <= 1'b1;
                        if (tick_c) overrun <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        if (tick_c) pending <= 1'b1;
                    end
                end
            endcase

            if (start_c) begin
                bin     <= bin_nxt;
                walk    <= walk_nxt;
                S100adr <= adr_nxt;
                s100_DO <= bin_nxt[DATA_W-1:0];
                sbcLEDS <= ~bin_nxt[7:0];
                cyc_wr  <= wr_next;
                wr_next <= ~wr_next;
            end
        end
    end

endmodule

// File: tb/tb_s100_bus_exerciser.sv
// Directed bench for s100_bus_exerciser.
module tb_s100_bus_exerciser;

    localparam int unsigned ADDR_W     = 20;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned PRESCALE_W = 24;
    localparam int unsigned HB_LOG2    = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  locked;
    logic [PRESCALE_W-1:0] prescale;
    logic [1:0]            mode;
    logic                  run;
    logic                  step;
    logic [ADDR_W-1:0]     adr;
    logic [DATA_W-1:0]     dout;
    logic [7:0]            leds;
    logic                  psync, pstval, pdbin, npwr, smwrt;
    logic                  busy, overrun, dp;
    logic [5:0]            strb;

    int total = 0;
    int bad   = 0;

    s100_bus_exerciser #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRESCALE_W(PRESCALE_W), .HB_LOG2(HB_LOG2)
    ) dut (
        .pll0_2MHz(clk), .s100_n_RESET(rst_n), .pll0_LOCKED(locked),
        .prescale(prescale), .mode(mode), .run(run), .step(step),
        .S100adr(adr), .s100_DO(dout), .sbcLEDS(leds),
        .s100_pSYNC(psync), .s100_pSTVAL(pstval), .s100_pDBIN(pdbin),
        .s100_n_pWR(npwr), .s100_sMWRT(smwrt),
        .busy(busy), .overrun(overrun), .seg7_dp(dp)
    );

    assign strb = {psync, pstval, pdbin, npwr, smwrt, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset(input logic [1:0] m, input logic [PRESCALE_W-1:0] ps);
        @(negedge clk);
        rst_n = 1'b0; run = 1'b0; step = 1'b0; locked = 1'b1;
        mode = m; prescale = ps;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(2'b00, 24'd0);
        total++;
        if (strb !== 6'b010100) begin
            bad++; $display("FAIL reset_strobes got=%b want=010100", strb);
        end
        total++;
        if ({adr, dout, leds, overrun, dp} !== {20'h0, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
            bad++; $display("FAIL reset_data adr=%h do=%h leds=%h ovr=%b dp=%b want 0/0/ff/0/0",
                            adr, dout, leds, overrun, dp);
        end
    endtask

    task automatic test_up_count();
        logic [5:0]        st_tbl [12];
        logic [ADDR_W-1:0] a_tbl  [12];
        st_tbl = '{6'b010100, 6'b010100, 6'b010100, 6'b110101, 6'b000101, 6'b011101,
                   6'b010100, 6'b110101, 6'b000111, 6'b010011, 6'b010100, 6'b110101};
        a_tbl  = '{20'd0, 20'd0, 20'd0, 20'd1, 20'd1, 20'd1,
                   20'd1, 20'd2, 20'd2, 20'd2, 20'd2, 20'd3};
        apply_reset(2'b00, 24'd3);
        run = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            total++;
            if (strb !== st_tbl[k] || adr !== a_tbl[k]) begin
                bad++; $display("FAIL up_clk%0d strb=%b adr=%h want strb=%b adr=%h",
                                k + 1, strb, adr, st_tbl[k], a_tbl[k]);
            end
        end
        total++;
        if (dout !== 8'h03 || leds !== 8'hFC) begin
            bad++; $display("FAIL up_data do=%h leds=%h want 03/fc", dout, leds);
        end
        run = 1'b0;
    endtask

    task automatic test_down();
        apply_reset(2'b01, 24'd0);
        pulse_step();
        total++;
        if (adr !== 20'hFFFFF || dout !== 8'hFF || leds !== 8'h00 || psync !== 1'b1) begin
            bad++; $display("FAIL down_first adr=%h do=%h leds=%h sync=%b want fffff/ff/00/1",
                            adr, dout, leds, psync);
        end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL down_idle busy=%b want 0", busy);
        end
    endtask

    task automatic test_walk();
        logic [ADDR_W-1:0] exp_a;
        apply_reset(2'b10, 24'd0);
        for (int k = 1; k <= 21; k++) begin
            pulse_step();
            exp_a = ADDR_W'(1) << (k % 20);
            total++;
            if (adr !== exp_a) begin
                bad++; $display("FAIL walk_%0d adr=%h want %h", k, adr, exp_a);
            end
            repeat (3) @(negedge clk);
        end
        total++;
        if (dout !== 8'h00 || leds !== 8'hFF) begin
            bad++; $display("FAIL walk_data do=%h leds=%h want 00/ff", dout, leds);
        end
    endtask

    task automatic test_gray_mode_change();
        logic [ADDR_W-1:0] g_tbl [4];
        g_tbl = '{20'd1, 20'd3, 20'd2, 20'd6};
        apply_reset(2'b11, 24'd0);
        for (int k = 0; k < 4; k++) begin
            pulse_step();
            total++;
            if (adr !== g_tbl[k]) begin
                bad++; $display("FAIL gray_%0d adr=%h want %h", k + 1, adr, g_tbl[k]);
            end
            repeat (3) @(negedge clk);
        end
        pulse_step();
        mode = 2'b00;
        total++;
        if (adr !== 20'd7) begin
            bad++; $display("FAIL gray_5 adr=%h want 7", adr);
        end
        @(negedge clk);
        total++;
        if (adr !== 20'd7) begin
            bad++; $display("FAIL mode_change_midcycle adr=%h want 7", adr);
        end
        repeat (2) @(negedge clk);
        pulse_step();
        total++;
        if (adr !== 20'd6 || dout !== 8'h06) begin
            bad++; $display("FAIL mode_change_next adr=%h do=%h want 6/06", adr, dout);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        apply_reset(2'b00, 24'd0);
        run = 1'b1;
        @(negedge clk);
        total++;
        if (psync !== 1'b1 || adr !== 20'd1 || overrun !== 1'b0) begin
            bad++; $display("FAIL b2b_k1 sync=%b adr=%h ovr=%b want 1/1/0", psync, adr, overrun);
        end
        @(negedge clk);
        total++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL b2b_pend ovr=%b busy=%b want 0/1", overrun, busy);
        end
        @(negedge clk);
        total++;
        if (overrun !== 1'b1) begin
            bad++; $display("FAIL b2b_overrun ovr=%b want 1", overrun);
        end
        @(negedge clk);
        run = 1'b0;
        total++;
        if (psync !== 1'b1 || busy !== 1'b1 || adr !== 20'd2) begin
            bad++; $display("FAIL b2b_resync sync=%b busy=%b adr=%h want 1/1/2", psync, busy, adr);
        end
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || overrun !== 1'b1) begin
            bad++; $display("FAIL b2b_end busy=%b ovr=%b want 0/1", busy, overrun);
        end
    endtask

    task automatic test_step_gating();
        apply_reset(2'b00, 24'd100);
        run = 1'b1;
        pulse_step();
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || adr !== 20'd0) begin
            bad++; $display("FAIL step_in_run busy=%b adr=%h want 0/0", busy, adr);
        end
        run = 1'b0; locked = 1'b0;
        @(negedge clk);
        pulse_step();
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL step_unlocked busy=%b want 0", busy);
        end
        locked = 1'b1;
        step = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b1 || adr !== 20'd1) begin
            bad++; $display("FAIL step_held_start busy=%b adr=%h want 1/1", busy, adr);
        end
        repeat (6) @(negedge clk);
        step = 1'b0;
        total++;
        if (busy !== 1'b0 || adr !== 20'd1) begin
            bad++; $display("FAIL step_held_once busy=%b adr=%h want 0/1", busy, adr);
        end
    endtask

    task automatic test_lock_drop();
        apply_reset(2'b00, 24'd0);
        run = 1'b1;
        repeat (2) @(negedge clk);
        locked = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (psync !== 1'b1 || adr !== 20'd2) begin
            bad++; $display("FAIL lock_pending sync=%b adr=%h want 1/2", psync, adr);
        end
        repeat (5) @(negedge clk);
        total++;
        if (busy !== 1'b0 || adr !== 20'd2 || overrun !== 1'b0) begin
            bad++; $display("FAIL lock_blocked busy=%b adr=%h ovr=%b want 0/2/0", busy, adr, overrun);
        end
        run = 1'b0; locked = 1'b1;
    endtask

    task automatic test_reset_mid_cycle();
        apply_reset(2'b00, 24'd0);
        pulse_step();
        repeat (2) @(negedge clk);
        total++;
        if (pdbin !== 1'b1 || npwr !== 1'b1 || adr !== 20'd1) begin
            bad++; $display("FAIL rst_mid_read dbin=%b wr=%b adr=%h want 1/1/1", pdbin, npwr, adr);
        end
        @(negedge clk);
        pulse_step();
        repeat (2) @(negedge clk);
        total++;
        if (pdbin !== 1'b0 || npwr !== 1'b0 || smwrt !== 1'b1 || adr !== 20'd2) begin
            bad++; $display("FAIL rst_mid_write dbin=%b wr=%b mwrt=%b adr=%h want 0/0/1/2",
                            pdbin, npwr, smwrt, adr);
        end
        @(negedge clk);
        pulse_step();
        @(negedge clk);
        total++;
        if (pstval !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_mid_status stval=%b busy=%b want 0/1", pstval, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (strb !== 6'b010100 || adr !== 20'd0 || dout !== 8'h00 || leds !== 8'hFF) begin
            bad++; $display("FAIL rst_async strb=%b adr=%h do=%h leds=%h want 010100/0/00/ff",
                            strb, adr, dout, leds);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_heartbeat();
        apply_reset(2'b00, 24'd3);
        run = 1'b1;
        repeat (1026) @(negedge clk);
        total++;
        if (dp !== 1'b0) begin
            bad++; $display("FAIL hb_before dp=%b want 0", dp);
        end
        @(negedge clk);
        total++;
        if (dp !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL hb_toggle dp=%b busy=%b want 1/0", dp, busy);
        end
        run = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; locked = 1'b1; prescale = '0; mode = 2'b00; run = 1'b0; step = 1'b0;
        test_reset();
        test_up_count();
        test_down();
        test_walk();
        test_gray_mode_change();
        test_back_to_back();
        test_step_gating();
        test_lock_drop();
        test_reset_mid_cycle();
        test_heartbeat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
